dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the CPU load/store path and the user/debug port
//  (switch input, display readback). Fixed CPU priority, with a starvation guard that forces a
//  user grant after MAX_WAIT lost cycles. Drives cpu_stall so the PC holds while the CPU is
//  blocked. Registers the user read data and acknowledge for the display path.
// PARAMETERS
//  AW        8   memory address width (byte address, matches the data-memory index)
//  DW        32  data width
//  MAX_WAIT  4   lost user-arbitration cycles before the user is forced ahead of the CPU
//                (0 = user always has priority)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   asynchronous reset, active-high
//  cpu_req    in   1   CPU memory access this cycle (lw or sw)
//  cpu_we     in   1   CPU write (sw)
//  cpu_addr   in   AW  CPU address (ALU result)
//  cpu_wdata  in   DW  CPU store data (rt register value)
//  cpu_rdata  out  DW  load data to the writeback mux; combinational from mem_rdata when CPU is granted, else 0
//  cpu_stall  out  1   combinational; high when cpu_req=1 and the CPU is not granted. PC, register file and writeback must hold.
//  usr_req    in   1   user access request; held high until usr_ack
//  usr_we     in   1   user write
//  usr_addr   in   AW  user address
//  usr_wdata  in   DW  user write data
//  usr_rdata  out  DW  registered user read data; holds until the next user grant
//  usr_ack    out  1   one-cycle pulse, the cycle after the user grant
//  mem_we     out  1   memory write enable, synchronous write at the clk edge
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data, combinational from mem_addr
// BEHAVIOUR
//  State machine:
//   - States: ARB, USR_DONE.
//   - ARB: arbitrate every cycle. A user grant moves to USR_DONE.
//   - USR_DONE: lasts exactly 1 cycle; usr_ack=1; the user is ineligible; the CPU may be granted. Then back to ARB.
//  Grant, combinational, evaluated in ARB:
//   - gnt=USR if usr_req && (!cpu_req || wait_cnt==MAX_WAIT).
//   - else gnt=CPU if cpu_req.
//   - else gnt=NONE.
//   - In USR_DONE: gnt=CPU if cpu_req, else NONE.
//  Memory port drive:
//   - gnt=CPU: mem_* <= cpu_*.
//   - gnt=USR: mem_* <= usr_*.
//   - gnt=NONE: mem_we=0, mem_addr=0, mem_wdata=0.
//   - mem_we is forced to 0 while rst=1, so no write can commit during reset.
//  wait_cnt:
//   - Increments, saturating at MAX_WAIT, on each ARB cycle with usr_req=1 and gnt!=USR.
//   - Clears on a user grant. Holds otherwise, including in USR_DONE.
//   - Width is clog2(MAX_WAIT+1), minimum 1.
//  User read:
//   - On the clk edge ending a USR grant cycle: usr_rdata <= mem_rdata (captured for writes too), usr_ack <= 1.
//   - Latency: grant cycle N, ack and data valid in cycle N+1.
//  Boundary cases:
//   - Worst-case CPU stall is 1 cycle per user transaction; user starvation is bounded by MAX_WAIT+1 cycles.
//   - usr_req still high in the USR_DONE cycle counts as a new request. It is eligible again in ARB.
//   - usr_req dropped before a grant: no access; wait_cnt holds its value.
//   - Simultaneous CPU sw and user write to the same address: only the granted one commits; no merging.
//  Reset (asynchronous, may arrive mid-transaction):
//   - state=ARB, wait_cnt=0, usr_ack=0, usr_rdata=0.
//   - A pending grant is abandoned; the requester must re-request.
// STRUCTURE
//  Shared package dmem_arb_pkg:
//   - Grant encoding: GNT_NONE=2'd0, GNT_CPU=2'd1, GNT_USR=2'd2.
//   - State encoding: ST_ARB=1'b0, ST_USR_DONE=1'b1.
//  Sub-module arb_wait_cnt: saturating counter (inputs inc, clr; output sat). Instantiated once.
//  Everything else (grant logic, port muxes, FSM, user-side registers) lives inline.
// TESTING
//  1 Reset: assert rst mid-cycle with usr_req=1 and cpu_req=1.
//    -> usr_ack=0, usr_rdata=0, mem_we=0 immediately; state ARB after release.
//  2 CPU only: sw addr 8'h10 data 32'hDEADBEEF, then lw 8'h10.
//    -> cpu_stall=0 both cycles; cpu_rdata=32'hDEADBEEF.
//  3 User only: usr write 8'h20=32'h00000ABC, then usr read 8'h20.
//    -> usr_ack pulses 1 cycle after each grant; usr_rdata=32'h00000ABC.
//  4 Starvation guard: cpu_req=1 continuously, usr_req=1, MAX_WAIT=4.
//    -> user granted in the 5th cycle; cpu_stall=1 in exactly that cycle; wait_cnt back to 0.
//  5 Contention: usr_req held high through its ack.
//    -> a second user grant no sooner than 2 cycles after the first; the CPU is served in the USR_DONE cycle.
//  6 MAX_WAIT=0: cpu_req and usr_req both high.
//    -> the user is granted first; the CPU is stalled 1 cycle, then granted in USR_DONE.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: grant owner, FSM state,
// and the width of the starvation counter.
package dmem_arb_pkg;
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_USR  = 2'd2
  } gnt_e;

  typedef enum logic {
    ST_ARB      = 1'b0,
    ST_USR_DONE = 1'b1
  } state_e;

  // clog2(max+1) with a floor of one bit so MAX_WAIT=0 still has a counter.
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction
endpackage

// File: rtl/arb_wait_cnt.sv
// Saturating count of user arbitration cycles lost to the CPU.
module arb_wait_cnt
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int W        = cnt_w(MAX_WAIT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);
  assign sat = (cnt == W'(MAX_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (inc && !sat) cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory shared by the CPU load/store path and the user port.
// CPU wins by default; the user is forced through after MAX_WAIT lost cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          usr_req,
  input  logic          usr_we,
  input  logic [AW-1:0] usr_addr,
  input  logic [DW-1:0] usr_wdata,
  output logic [DW-1:0] usr_rdata,
  output logic          usr_ack,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int CW = cnt_w(MAX_WAIT);

  state_e        state;
  gnt_e          gnt;
  logic [CW-1:0] wait_cnt;
  logic          wait_sat;
  logic          wait_inc;
  logic          wait_clr;
  logic          mux_we;

  // The user is never eligible in USR_DONE, so an ack cannot be re-issued back to back.
  always_comb begin
    gnt = GNT_NONE;
    if (state == ST_ARB && usr_req && (!cpu_req || wait_sat)) gnt = GNT_USR;
    else if (cpu_req)                                        gnt = GNT_CPU;
  end

  always_comb begin
    mux_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (gnt)
      GNT_CPU: begin
        mux_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      GNT_USR: begin
        mux_we    = usr_we;
        mem_addr  = usr_addr;
        mem_wdata = usr_wdata;
      end
      default: ;
    endcase
  end

  // Gate the write strobe with reset so nothing commits while the block is held.
  assign mem_we    = mux_we && !rst;
  assign cpu_rdata = (gnt == GNT_CPU) ? mem_rdata : '0;
  assign cpu_stall = cpu_req && (gnt != GNT_CPU);

  assign wait_inc = (state == ST_ARB) && usr_req && (gnt != GNT_USR);
  assign wait_clr = (gnt == GNT_USR);

  arb_wait_cnt #(
    .MAX_WAIT (MAX_WAIT),
    .W        (CW)
  ) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .inc (wait_inc),
    .clr (wait_clr),
    .cnt (wait_cnt),
    .sat (wait_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ARB;
      usr_ack   <= 1'b0;
      usr_rdata <= '0;
    end else begin
      usr_ack <= 1'b0;
      case (state)
        ST_ARB: begin
          if (gnt == GNT_USR) begin
            state     <= ST_USR_DONE;
            usr_ack   <= 1'b1;
            usr_rdata <= mem_rdata;
          end
        end
        ST_USR_DONE: state <= ST_ARB;
        default:     state <= ST_ARB;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance at MAX_WAIT=4 backed by a
// behavioural memory, and one at MAX_WAIT=0 for the user-first corner.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  // Instance A, MAX_WAIT=4
  logic        cpu_req = 0, cpu_we = 0, usr_req = 0, usr_we = 0;
  logic [7:0]  cpu_addr = '0, usr_addr = '0, mem_addr;
  logic [31:0] cpu_wdata = '0, usr_wdata = '0, cpu_rdata, usr_rdata, mem_wdata, mem_rdata;
  logic        cpu_stall, usr_ack, mem_we;

  dmem_arbiter #(.AW(8), .DW(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .usr_req(usr_req), .usr_we(usr_we), .usr_addr(usr_addr), .usr_wdata(usr_wdata),
    .usr_rdata(usr_rdata), .usr_ack(usr_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [256];
  logic        clr_mem = 1'b1;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (clr_mem) for (int i = 0; i < 256; i++) mem[i] <= '0;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Instance B, MAX_WAIT=0; read data is a fixed function of the address
  logic        b_cpu_req = 0, b_cpu_we = 0, b_usr_req = 0, b_usr_we = 0;
  logic [7:0]  b_cpu_addr = '0, b_usr_addr = '0, b_mem_addr;
  logic [31:0] b_cpu_wdata = '0, b_usr_wdata = '0, b_cpu_rdata, b_usr_rdata, b_mem_wdata, b_mem_rdata;
  logic        b_cpu_stall, b_usr_ack, b_mem_we;

  assign b_mem_rdata = 32'hA500_0000 | {24'h0, b_mem_addr};

  dmem_arbiter #(.AW(8), .DW(32), .MAX_WAIT(0)) dut_b (
    .clk(clk), .rst(rst),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
    .usr_req(b_usr_req), .usr_we(b_usr_we), .usr_addr(b_usr_addr), .usr_wdata(b_usr_wdata),
    .usr_rdata(b_usr_rdata), .usr_ack(b_usr_ack),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick; tick;
    chk("rst_ack", usr_ack, 0);
    chk("rst_rdata", usr_rdata, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_stall", cpu_stall, 0);
    clr_mem = 1'b0;
    rst = 1'b0;

    // CPU only: store then load
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 32'hDEADBEEF; #1;
    chk("sw_stall", cpu_stall, 0);
    chk("sw_mem_we", mem_we, 1);
    chk("sw_mem_addr", mem_addr, 8'h10);
    tick;
    cpu_we = 0; #1;
    chk("lw_stall", cpu_stall, 0);
    chk("lw_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("lw_mem_we", mem_we, 0);
    tick;
    cpu_req = 0;

    // User only: write then read back
    usr_req = 1; usr_we = 1; usr_addr = 8'h20; usr_wdata = 32'h00000ABC; #1;
    chk("uw_mem_we", mem_we, 1);
    chk("uw_ack_grant_cycle", usr_ack, 0);
    tick;
    chk("uw_ack", usr_ack, 1);
    usr_req = 0; usr_we = 0;
    tick;
    chk("uw_ack_pulse", usr_ack, 0);
    usr_req = 1; #1;
    chk("ur_mem_addr", mem_addr, 8'h20);
    tick;
    chk("ur_ack", usr_ack, 1);
    chk("ur_rdata", usr_rdata, 32'h00000ABC);

    // Asynchronous reset in the USR_DONE cycle with a CPU store pending
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h30; cpu_wdata = 32'h1234; #1;
    chk("pre_rst_mem_we", mem_we, 1);
    rst = 1; #1;
    chk("arst_ack", usr_ack, 0);
    chk("arst_rdata", usr_rdata, 0);
    chk("arst_mem_we", mem_we, 0);
    tick;
    chk("arst_no_commit", mem[8'h30], 0);
    rst = 0; cpu_req = 0; cpu_we = 0; #1;
    chk("post_rst_state", dut.state, 0);
    chk("post_rst_regrant", mem_addr, 8'h20);
    tick;
    chk("post_rst_ack", usr_ack, 1);
    chk("post_rst_rdata", usr_rdata, 32'h00000ABC);
    usr_req = 0;
    tick;

    // Starvation guard: user forced through in the 5th contended cycle
    cpu_req = 1; cpu_addr = 8'h10; usr_req = 1; usr_addr = 8'h20;
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk($sformatf("starve_stall_%0d", k), cpu_stall, (k == 5) ? 1 : 0);
      chk($sformatf("starve_cnt_%0d", k), dut.wait_cnt, k - 1);
      tick;
    end
    chk("starve_ack", usr_ack, 1);
    chk("starve_cnt_clr", dut.wait_cnt, 0);
    #1;
    // USR_DONE with usr_req still high: CPU is served
    chk("done_stall", cpu_stall, 0);
    chk("done_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    tick;
    chk("done_cnt_hold", dut.wait_cnt, 0);
    chk("done_ack_drop", usr_ack, 0);
    cpu_req = 0; #1;
    chk("regrant_addr", mem_addr, 8'h20);
    tick;
    chk("regrant_ack", usr_ack, 1);
    usr_req = 0;
    tick;

    // Request withdrawn before a grant: counter holds
    cpu_req = 1; usr_req = 1;
    tick; tick;
    usr_req = 0;
    tick;
    chk("drop_cnt_hold", dut.wait_cnt, 2);
    chk("drop_no_ack", usr_ack, 0);
    usr_req = 1; cpu_req = 0;
    tick;
    chk("drop_regrant_ack", usr_ack, 1);
    chk("drop_cnt_clr", dut.wait_cnt, 0);
    usr_req = 0;
    tick;

    // Same-address writes: CPU commits first, then the user overwrites
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h40; cpu_wdata = 32'h11111111;
    usr_req = 1; usr_we = 1; usr_addr = 8'h40; usr_wdata = 32'h22222222; #1;
    chk("coll_cpu_wdata", mem_wdata, 32'h11111111);
    tick;
    chk("coll_cpu_commit", mem[8'h40], 32'h11111111);
    cpu_req = 0; cpu_we = 0; #1;
    chk("coll_usr_wdata", mem_wdata, 32'h22222222);
    tick;
    chk("coll_usr_ack", usr_ack, 1);
    chk("coll_usr_commit", mem[8'h40], 32'h22222222);
    usr_req = 0; usr_we = 0;
    tick;

    // MAX_WAIT=0: user first, CPU stalled once then served in USR_DONE
    b_cpu_req = 1; b_cpu_addr = 8'h05; b_usr_req = 1; b_usr_addr = 8'h07; #1;
    chk("mw0_stall", b_cpu_stall, 1);
    chk("mw0_mem_addr", b_mem_addr, 8'h07);
    tick;
    chk("mw0_ack", b_usr_ack, 1);
    chk("mw0_usr_rdata", b_usr_rdata, 32'hA5000007);
    b_usr_req = 0; #1;
    chk("mw0_done_stall", b_cpu_stall, 0);
    chk("mw0_cpu_rdata", b_cpu_rdata, 32'hA5000005);
    tick;
    b_cpu_req = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
